mem_axi_arbiter: RTL and testbench
==================================

Name: mem_axi_arbiter

Overview:
- Shares one AXI memory port between the instruction cache (read-only) and the data cache (read and write).
- Sits between the icache/dcache wrappers and the memory-side AXI interface.
- Read bursts from the two caches are serialised with round-robin arbitration.
- The dcache AW/W/B path is sequenced so that a write transaction completes, including its B response, before any read is granted.
- Burst lengths are checked, and a sticky error flag is raised on a mismatch.

Parameters:
- ADDR_W, 32, cache-side address width; memory side is {8'd0, addr} (40 bits).
- DATA_W, 32, data beat width.
- LEN_W, 8, AXI burst length field width.

Ports:
- cpu_clk  in  1  single clock.
- cpu_reset_n  in  1  asynchronous, active-low reset.
- ic_araddr  in  ADDR_W  icache read address.
- ic_arlen  in  LEN_W  icache read burst length.
- ic_arvalid  in  1  icache read request valid.
- ic_arready  out  1  icache read request ready.
- ic_rdata  out  DATA_W  icache read data.
- ic_rvalid  out  1  icache read data valid.
- ic_rlast  out  1  icache read data last beat.
- ic_rready  in  1  icache read data ready.
- dc_araddr, dc_arlen, dc_arvalid, dc_arready, dc_rdata, dc_rvalid, dc_rlast, dc_rready: dcache read port, same directions and widths as the icache set.
- dc_awaddr  in  ADDR_W  dcache write address.
- dc_awlen  in  LEN_W  dcache write burst length.
- dc_awvalid  in  1  dcache write request valid.
- dc_awready  out  1  dcache write request ready.
- dc_wdata  in  DATA_W  dcache write data.
- dc_wstrb  in  4  dcache write byte strobes.
- dc_wvalid  in  1  dcache write data valid.
- dc_wlast  in  1  dcache write data last beat.
- dc_wready  out  1  dcache write data ready.
- mem_araddr  out  40  memory read address.
- mem_arlen  out  LEN_W  memory read burst length.
- mem_arsize  out  3  memory read size.
- mem_arburst  out  2  memory read burst type.
- mem_arvalid  out  1  memory read request valid.
- mem_arready  in  1  memory read request ready.
- mem_rdata  in  DATA_W  memory read data.
- mem_rvalid  in  1  memory read data valid.
- mem_rlast  in  1  memory read data last beat.
- mem_rready  out  1  memory read data ready.
- mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_awvalid, mem_awready: memory write-address channel, same shape as the AR set.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  4  memory write byte strobes.
- mem_wvalid  out  1  memory write data valid.
- mem_wlast  out  1  memory write data last beat.
- mem_wready  in  1  memory write data ready.
- mem_bvalid  in  1  memory write response valid.
- mem_bready  out  1  memory write response ready.
- len_err  out  1  sticky burst-length mismatch flag.

Behaviour:
- Constant outputs: arsize = awsize = 3'b010; arburst = awburst = 2'b01.
- Reset (async assert, sync release):
  - Both FSMs go to IDLE; the priority pointer selects dcache.
  - All valid/ready outputs are 0, mem_bready = 0, len_err = 0.
  - Latched address/length registers are 0.
- A reset mid-burst abandons the transaction; no completion is emitted.
- Read FSM states: RD_IDLE, RD_AR, RD_DATA.
  - RD_IDLE -> RD_AR when the write FSM is W_IDLE, no write start occurs this cycle, and at least one arvalid is high.
  - Grant selection: if only one cache requests, it wins. If both request, the cache named by the pointer wins, and the pointer then flips to the other cache.
  - On the transition, the winner's addr/len are latched and grant_id is recorded.
  - RD_AR: mem_arvalid = 1 with the latched values. The granted master's arready = mem_arready; the other master's arready = 0. On the AR handshake, go to RD_DATA.
  - RD_DATA: mem_rready = granted rready. The granted master sees rvalid = mem_rvalid and rdata/rlast passthrough; the other master's rvalid = 0. Return to RD_IDLE on the handshake with mem_rlast = 1.
  - The earliest next grant is the cycle after the return to RD_IDLE (no back-to-back overlap).
- Write FSM states: W_IDLE, W_AW, W_DATA, W_RESP.
  - W_IDLE -> W_AW when dc_awvalid is high and the read FSM is in RD_IDLE. If a read request and dc_awvalid arrive in the same cycle, the write wins (dirty eviction precedes refill).
  - awaddr/awlen are latched on that transition.
  - W_AW: mem_awvalid = 1; dc_awready = mem_awready. On the handshake, go to W_DATA.
  - W_DATA: W channel passes through combinationally (mem_wvalid = dc_wvalid, dc_wready = mem_wready, data/strb/last passthrough). Go to W_RESP on a handshake with dc_wlast = 1.
  - W_RESP: mem_bready = 1. On mem_bvalid, return to W_IDLE. B is not forwarded.
- Beat counter (LEN_W+1 bits):
  - Cleared on entering RD_DATA or W_DATA; increments on each data handshake.
  - If a last beat arrives with count != latched len, or count exceeds len without last, len_err sets and stays set until reset.
  - Transfers are not altered on error.
- Ready/valid outputs to the caches in non-owning states are 0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the read and write state enums;
  - the grant ids GNT_IC = 0 and GNT_DC = 1;
  - the AXI constants SIZE_4B = 3'b010 and BURST_INCR = 2'b01.
- One natural sub-module: rr_arb2, a two-requester round-robin grant with a pointer register.

Test Plan:
- icache only: ic_arvalid with addr 0x1000, len 7; memory returns 8 beats 0xA0..0xA7.
  -> mem_araddr = 0x00_0000_1000, ic receives all 8 beats with rlast on the 8th, dc_rvalid stays 0, len_err = 0.
- Simultaneous ic and dc reads after reset.
  -> dcache granted first, icache second.
  -> A repeat of the simultaneous pair then grants icache first.
- dc_awvalid (addr 0x2000, len 3) and ic_arvalid in the same cycle.
  -> AW issued first; the read AR is not issued until the cycle after mem_bvalid (B delayed 5 cycles).
- Write with mem_wready toggling every other cycle.
  -> exactly 4 W handshakes, strobes 0xF passed unchanged, mem_bready high only in W_RESP.
- Memory asserts rlast on beat 3 of a len=7 read.
  -> len_err rises and stays 1; the FSM returns to RD_IDLE.
- cpu_reset_n pulsed low during RD_DATA beat 2.
  -> all valids drop asynchronously, pointer = dcache, next request served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory AXI arbiter.
//   - rd_state_e / wr_state_e : read and write sequencer states
//   - GNT_IC / GNT_DC         : grant ids (also bit positions in request vectors)
//   - SIZE_4B / BURST_INCR    : fixed AXI size and burst encodings
package mem_arb_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/mem_axi_arbiter_if.sv
// Bus bundle between the icache/dcache wrappers, the arbiter and the memory
// AXI port.
//   slave  : arbiter view (cache requests and memory responses are inputs)
//   master : environment view (caches + memory drive the arbiter's inputs)
interface mem_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  // icache read port
  logic [ADDR_W-1:0]   ic_araddr;
  logic [LEN_W-1:0]    ic_arlen;
  logic                ic_arvalid, ic_arready;
  logic [DATA_W-1:0]   ic_rdata;
  logic                ic_rvalid, ic_rlast, ic_rready;
  // dcache read port
  logic [ADDR_W-1:0]   dc_araddr;
  logic [LEN_W-1:0]    dc_arlen;
  logic                dc_arvalid, dc_arready;
  logic [DATA_W-1:0]   dc_rdata;
  logic                dc_rvalid, dc_rlast, dc_rready;
  // dcache write port
  logic [ADDR_W-1:0]   dc_awaddr;
  logic [LEN_W-1:0]    dc_awlen;
  logic                dc_awvalid, dc_awready;
  logic [DATA_W-1:0]   dc_wdata;
  logic [3:0]          dc_wstrb;
  logic                dc_wvalid, dc_wlast, dc_wready;
  // memory side
  logic [ADDR_W+7:0]   mem_araddr;
  logic [LEN_W-1:0]    mem_arlen;
  logic [2:0]          mem_arsize;
  logic [1:0]          mem_arburst;
  logic                mem_arvalid, mem_arready;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rvalid, mem_rlast, mem_rready;
  logic [ADDR_W+7:0]   mem_awaddr;
  logic [LEN_W-1:0]    mem_awlen;
  logic [2:0]          mem_awsize;
  logic [1:0]          mem_awburst;
  logic                mem_awvalid, mem_awready;
  logic [DATA_W-1:0]   mem_wdata;
  logic [3:0]          mem_wstrb;
  logic                mem_wvalid, mem_wlast, mem_wready;
  logic                mem_bvalid, mem_bready;

  modport slave (
    input  ic_araddr, ic_arlen, ic_arvalid, ic_rready,
    output ic_arready, ic_rdata, ic_rvalid, ic_rlast,
    input  dc_araddr, dc_arlen, dc_arvalid, dc_rready,
    output dc_arready, dc_rdata, dc_rvalid, dc_rlast,
    input  dc_awaddr, dc_awlen, dc_awvalid, dc_wdata, dc_wstrb, dc_wvalid, dc_wlast,
    output dc_awready, dc_wready,
    output mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arvalid, mem_rready,
    input  mem_arready, mem_rdata, mem_rvalid, mem_rlast,
    output mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_awvalid,
    output mem_wdata, mem_wstrb, mem_wvalid, mem_wlast, mem_bready,
    input  mem_awready, mem_wready, mem_bvalid
  );

  modport master (
    output ic_araddr, ic_arlen, ic_arvalid, ic_rready,
    input  ic_arready, ic_rdata, ic_rvalid, ic_rlast,
    output dc_araddr, dc_arlen, dc_arvalid, dc_rready,
    input  dc_arready, dc_rdata, dc_rvalid, dc_rlast,
    output dc_awaddr, dc_awlen, dc_awvalid, dc_wdata, dc_wstrb, dc_wvalid, dc_wlast,
    input  dc_awready, dc_wready,
    input  mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arvalid, mem_rready,
    output mem_arready, mem_rdata, mem_rvalid, mem_rlast,
    input  mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_awvalid,
    input  mem_wdata, mem_wstrb, mem_wvalid, mem_wlast, mem_bready,
    output mem_awready, mem_wready, mem_bvalid
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i[1:0]    : requests, indexed by GNT_IC / GNT_DC
//   take_i        : grant is consumed this cycle
//   gnt_o         : winning grant id
// The pointer only moves when both requested, so a lone requester never
// steals the other's turn.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o
);

  logic ptr_q;

  always_comb begin
    if (req_i[GNT_DC] && req_i[GNT_IC]) gnt_o = ptr_q;
    else if (req_i[GNT_DC])             gnt_o = GNT_DC;
    else                                gnt_o = GNT_IC;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   ptr_q <= GNT_DC;
    else if (take_i && (&req_i))   ptr_q <= ~ptr_q;
  end

endmodule

// File: rtl/mem_axi_arbiter.sv
// Shares one AXI memory port between the icache (read only) and the dcache
// (read + write). Reads are serialised round-robin; a dcache write runs to
// its B response before any read is granted. A sticky len_err flags bursts
// whose beat count disagrees with the requested length.
//   cpu_clk, cpu_reset_n : clock, async active-low reset
//   bus                  : cache-side and memory-side AXI signals (slave view)
//   len_err              : sticky burst-length mismatch
module mem_axi_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                cpu_clk,
  input  logic                cpu_reset_n,
  mem_axi_arbiter_if.slave    bus,
  output logic                len_err
);

  rd_state_e          rd_state_q;
  wr_state_e          wr_state_q;
  logic               grant_q;
  logic [ADDR_W-1:0]  ar_addr_q, aw_addr_q;
  logic [LEN_W-1:0]   ar_len_q, aw_len_q;
  logic [LEN_W:0]     beat_cnt_q;
  logic               len_err_q;

  logic rd_ar, rd_data, w_aw, w_data, w_resp;
  logic wr_start, rd_start, rd_gnt;
  logic ar_hs, r_hs, aw_hs, w_hs;
  logic beat_hs, beat_last, beat_bad;
  logic [LEN_W:0] cur_len;

  assign rd_ar   = (rd_state_q == RD_AR);
  assign rd_data = (rd_state_q == RD_DATA);
  assign w_aw    = (wr_state_q == W_AW);
  assign w_data  = (wr_state_q == W_DATA);
  assign w_resp  = (wr_state_q == W_RESP);

  // A pending write beats a same-cycle read: dirty eviction precedes refill.
  assign wr_start = (wr_state_q == W_IDLE) && (rd_state_q == RD_IDLE) && bus.dc_awvalid;
  assign rd_start = (rd_state_q == RD_IDLE) && (wr_state_q == W_IDLE) && !wr_start &&
                    (bus.ic_arvalid || bus.dc_arvalid);

  rr_arb2 u_rr (
    .clk_i  (cpu_clk),
    .rst_ni (cpu_reset_n),
    .req_i  ({bus.dc_arvalid, bus.ic_arvalid}),
    .take_i (rd_start),
    .gnt_o  (rd_gnt)
  );

  // Read channels
  assign bus.mem_arvalid = rd_ar;
  assign bus.mem_araddr  = {8'd0, ar_addr_q};
  assign bus.mem_arlen   = ar_len_q;
  assign bus.mem_arsize  = SIZE_4B;
  assign bus.mem_arburst = BURST_INCR;
  assign bus.ic_arready  = rd_ar && (grant_q == GNT_IC) && bus.mem_arready;
  assign bus.dc_arready  = rd_ar && (grant_q == GNT_DC) && bus.mem_arready;
  assign bus.mem_rready  = rd_data && ((grant_q == GNT_DC) ? bus.dc_rready : bus.ic_rready);
  assign bus.ic_rvalid   = rd_data && (grant_q == GNT_IC) && bus.mem_rvalid;
  assign bus.dc_rvalid   = rd_data && (grant_q == GNT_DC) && bus.mem_rvalid;
  assign bus.ic_rlast    = rd_data && (grant_q == GNT_IC) && bus.mem_rlast;
  assign bus.dc_rlast    = rd_data && (grant_q == GNT_DC) && bus.mem_rlast;
  assign bus.ic_rdata    = bus.mem_rdata;
  assign bus.dc_rdata    = bus.mem_rdata;

  // Write channels
  assign bus.mem_awvalid = w_aw;
  assign bus.mem_awaddr  = {8'd0, aw_addr_q};
  assign bus.mem_awlen   = aw_len_q;
  assign bus.mem_awsize  = SIZE_4B;
  assign bus.mem_awburst = BURST_INCR;
  assign bus.dc_awready  = w_aw && bus.mem_awready;
  assign bus.mem_wvalid  = w_data && bus.dc_wvalid;
  assign bus.dc_wready   = w_data && bus.mem_wready;
  assign bus.mem_wdata   = bus.dc_wdata;
  assign bus.mem_wstrb   = bus.dc_wstrb;
  assign bus.mem_wlast   = w_data && bus.dc_wlast;
  assign bus.mem_bready  = w_resp;

  assign ar_hs = rd_ar && bus.mem_arready;
  assign r_hs  = rd_data && bus.mem_rvalid && bus.mem_rready;
  assign aw_hs = w_aw && bus.mem_awready;
  assign w_hs  = w_data && bus.dc_wvalid && bus.mem_wready;

  // Reads and writes never overlap, so one beat counter serves both.
  // beat_cnt_q is the index of the beat being transferred; the last beat
  // must carry index == len, and no beat past index len may be non-last.
  assign beat_hs   = r_hs || w_hs;
  assign beat_last = rd_data ? bus.mem_rlast : bus.dc_wlast;
  assign cur_len   = rd_data ? {1'b0, ar_len_q} : {1'b0, aw_len_q};
  assign beat_bad  = beat_hs && (beat_last ? (beat_cnt_q != cur_len) : (beat_cnt_q >= cur_len));
  assign len_err   = len_err_q;

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      rd_state_q <= RD_IDLE;
      grant_q    <= GNT_DC;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (rd_start) begin
          rd_state_q <= RD_AR;
          grant_q    <= rd_gnt;
          ar_addr_q  <= (rd_gnt == GNT_DC) ? bus.dc_araddr : bus.ic_araddr;
          ar_len_q   <= (rd_gnt == GNT_DC) ? bus.dc_arlen  : bus.ic_arlen;
        end
        RD_AR:   if (ar_hs) rd_state_q <= RD_DATA;
        RD_DATA: if (r_hs && bus.mem_rlast) rd_state_q <= RD_IDLE;
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      wr_state_q <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (wr_start) begin
          wr_state_q <= W_AW;
          aw_addr_q  <= bus.dc_awaddr;
          aw_len_q   <= bus.dc_awlen;
        end
        W_AW:    if (aw_hs) wr_state_q <= W_DATA;
        W_DATA:  if (w_hs && bus.dc_wlast) wr_state_q <= W_RESP;
        W_RESP:  if (bus.mem_bvalid) wr_state_q <= W_IDLE;
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      if (ar_hs || aw_hs)  beat_cnt_q <= '0;
      else if (beat_hs)    beat_cnt_q <= beat_cnt_q + {{LEN_W{1'b0}}, 1'b1};
      if (beat_bad)        len_err_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_axi_arbiter.sv
module tb_mem_axi_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic len_err;

  always #5 clk = ~clk;

  mem_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  mem_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .cpu_clk     (clk),
    .cpu_reset_n (rst_n),
    .bus         (bus),
    .len_err     (len_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: who wins the next contended read, and the
  // expected sticky error flag.
  logic pref    = GNT_DC;
  logic err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input logic ic_req, input logic dc_req);
    logic w;
    if (ic_req && dc_req) begin
      w    = pref;
      pref = ~pref;
    end else begin
      w = dc_req ? GNT_DC : GNT_IC;
    end
    return w;
  endfunction

  task automatic clear_inputs();
    bus.ic_araddr = '0; bus.ic_arlen = '0; bus.ic_arvalid = 0; bus.ic_rready = 0;
    bus.dc_araddr = '0; bus.dc_arlen = '0; bus.dc_arvalid = 0; bus.dc_rready = 0;
    bus.dc_awaddr = '0; bus.dc_awlen = '0; bus.dc_awvalid = 0;
    bus.dc_wdata = '0; bus.dc_wstrb = '0; bus.dc_wvalid = 0; bus.dc_wlast = 0;
    bus.mem_arready = 0; bus.mem_rdata = '0; bus.mem_rvalid = 0; bus.mem_rlast = 0;
    bus.mem_awready = 0; bus.mem_wready = 0; bus.mem_bvalid = 0;
  endtask

  // Serve one read burst for whichever cache the model says wins.
  // last_at < 0 means memory ends the burst at the requested length.
  task automatic serve_read(input int last_at, input bit seq, input logic [31:0] base,
                            input bit rand_ready);
    logic who;
    logic [31:0] addr, d;
    logic [7:0] len;
    logic rr;
    int n, la;
    who  = pick(bus.ic_arvalid, bus.dc_arvalid);
    addr = who ? bus.dc_araddr : bus.ic_araddr;
    len  = who ? bus.dc_arlen : bus.ic_arlen;
    la   = (last_at < 0) ? int'(len) : last_at;
    n = 0;
    while (bus.mem_arvalid !== 1'b1 && n < 50) begin cyc(); n++; end
    chk("ar_wait", bus.mem_arvalid, 1);
    chk("araddr", bus.mem_araddr, {8'd0, addr});
    chk("arlen", bus.mem_arlen, len);
    chk("arsize", bus.mem_arsize, 3'b010);
    chk("arburst", bus.mem_arburst, 2'b01);
    bus.mem_arready = 1; #1;
    chk("arready_win", who ? bus.dc_arready : bus.ic_arready, 1);
    chk("arready_lose", who ? bus.ic_arready : bus.dc_arready, 0);
    cyc();
    bus.mem_arready = 0;
    if (who) bus.dc_arvalid = 0; else bus.ic_arvalid = 0;
    for (int i = 0; i <= la; i++) begin
      d = seq ? base + 32'(i) : $urandom;
      bus.mem_rdata = d; bus.mem_rvalid = 1; bus.mem_rlast = (i == la);
      n = 0;
      do begin
        rr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (n > 20) rr = 1'b1;
        if (who) bus.dc_rready = rr; else bus.ic_rready = rr;
        #1;
        chk("rvalid_win", who ? bus.dc_rvalid : bus.ic_rvalid, 1);
        chk("rvalid_lose", who ? bus.ic_rvalid : bus.dc_rvalid, 0);
        chk("rdata", who ? bus.dc_rdata : bus.ic_rdata, d);
        chk("rlast", who ? bus.dc_rlast : bus.ic_rlast, (i == la));
        chk("mem_rready", bus.mem_rready, rr);
        cyc(); n++;
      end while (!rr);
      if (i == la) err_exp = err_exp | (i != int'(len));
      else         err_exp = err_exp | (i >= int'(len));
    end
    bus.mem_rvalid = 0; bus.mem_rlast = 0; bus.ic_rready = 0; bus.dc_rready = 0;
    #1;
    chk("len_err", len_err, err_exp);
    chk("no_b2b_ar", bus.mem_arvalid, 0);
    $display("[TB] read %s addr=%08h len=%0d beats=%0d len_err=%0b",
             who ? "dc" : "ic", addr, len, la + 1, len_err);
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [7:0] len, input bit toggle,
                             input int bdelay, input bit fixed_strb);
    logic [31:0] d;
    logic [3:0] s;
    logic wr;
    int n, hs;
    bus.dc_awaddr = addr; bus.dc_awlen = len; bus.dc_awvalid = 1;
    n = 0;
    while (bus.mem_awvalid !== 1'b1 && n < 50) begin cyc(); n++; end
    chk("aw_wait", bus.mem_awvalid, 1);
    chk("awaddr", bus.mem_awaddr, {8'd0, addr});
    chk("awlen", bus.mem_awlen, len);
    chk("awsize", bus.mem_awsize, 3'b010);
    chk("awburst", bus.mem_awburst, 2'b01);
    bus.mem_awready = 1; #1;
    chk("dc_awready", bus.dc_awready, 1);
    cyc();
    bus.mem_awready = 0; bus.dc_awvalid = 0;
    hs = 0; n = 0;
    for (int i = 0; i <= int'(len); i++) begin
      d = $urandom;
      s = fixed_strb ? 4'hF : 4'($urandom);
      bus.dc_wdata = d; bus.dc_wstrb = s; bus.dc_wvalid = 1; bus.dc_wlast = (i == int'(len));
      do begin
        wr = toggle ? n[0] : 1'b1;
        bus.mem_wready = wr; #1;
        chk("wvalid", bus.mem_wvalid, 1);
        chk("wdata", bus.mem_wdata, d);
        chk("wstrb", bus.mem_wstrb, s);
        chk("wlast", bus.mem_wlast, (i == int'(len)));
        chk("dc_wready", bus.dc_wready, wr);
        chk("bready_in_w", bus.mem_bready, 0);
        chk("ar_during_w", bus.mem_arvalid, 0);
        if (bus.mem_wvalid && bus.mem_wready) hs++;
        cyc(); n++;
      end while (!wr && n < 100);
    end
    bus.dc_wvalid = 0; bus.dc_wlast = 0; bus.mem_wready = 0;
    chk("w_beats", hs, int'(len) + 1);
    for (int b = 0; b < bdelay; b++) begin
      #1;
      chk("bready_wait", bus.mem_bready, 1);
      chk("ar_during_b", bus.mem_arvalid, 0);
      cyc();
    end
    bus.mem_bvalid = 1; #1;
    chk("bready_b", bus.mem_bready, 1);
    cyc();
    bus.mem_bvalid = 0; #1;
    chk("bready_after", bus.mem_bready, 0);
    $display("[TB] write addr=%08h len=%0d w_hs=%0d bdelay=%0d", addr, len, hs, bdelay);
  endtask

  initial begin
    int n;
    int kind;
    clear_inputs();
    rst_n = 0;
    cyc(); cyc();
    // Reset state
    chk("rst_arvalid", bus.mem_arvalid, 0);
    chk("rst_awvalid", bus.mem_awvalid, 0);
    chk("rst_rready", bus.mem_rready, 0);
    chk("rst_bready", bus.mem_bready, 0);
    chk("rst_wvalid", bus.mem_wvalid, 0);
    chk("rst_araddr", bus.mem_araddr, 0);
    chk("rst_arlen", bus.mem_arlen, 0);
    chk("rst_awaddr", bus.mem_awaddr, 0);
    chk("rst_len_err", len_err, 0);
    $display("[TB] reset released");
    rst_n = 1;
    cyc();

    // icache alone, sequential data 0xA0..0xA7
    bus.ic_araddr = 32'h1000; bus.ic_arlen = 8'd7; bus.ic_arvalid = 1;
    serve_read(-1, 1, 32'hA0, 0);

    // Contended reads: dcache first after reset, icache first on repeat
    for (int r = 0; r < 2; r++) begin
      bus.ic_araddr = $urandom; bus.ic_arlen = 8'($urandom_range(0, 7)); bus.ic_arvalid = 1;
      bus.dc_araddr = $urandom; bus.dc_arlen = 8'($urandom_range(0, 7)); bus.dc_arvalid = 1;
      chk("contend_first", pref, (r == 0) ? GNT_DC : GNT_IC);
      serve_read(-1, 0, 0, 1);
      serve_read(-1, 0, 0, 1);
    end

    // Write and read in the same cycle: write first, AR the cycle after B+1
    bus.ic_araddr = $urandom; bus.ic_arlen = 8'd3; bus.ic_arvalid = 1;
    serve_write(32'h2000, 8'd3, 0, 5, 1);
    chk("ar_after_b_0", bus.mem_arvalid, 0);
    cyc();
    chk("ar_after_b_1", bus.mem_arvalid, 1);
    serve_read(-1, 0, 0, 0);

    // Write with mem_wready toggling
    serve_write($urandom, 8'd3, 1, 1, 1);

    // Randomised mix
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: serve_write($urandom, 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), 0);
        1: begin
          bus.ic_araddr = $urandom; bus.ic_arlen = 8'($urandom_range(0, 7)); bus.ic_arvalid = 1;
          serve_read(-1, 0, 0, 1);
        end
        2: begin
          bus.dc_araddr = $urandom; bus.dc_arlen = 8'($urandom_range(0, 7)); bus.dc_arvalid = 1;
          serve_read(-1, 0, 0, 1);
        end
        default: begin
          bus.ic_araddr = $urandom; bus.ic_arlen = 8'($urandom_range(0, 7)); bus.ic_arvalid = 1;
          bus.dc_araddr = $urandom; bus.dc_arlen = 8'($urandom_range(0, 7)); bus.dc_arvalid = 1;
          serve_read(-1, 0, 0, 1);
          serve_read(-1, 0, 0, 1);
        end
      endcase
    end

    // Early rlast on the third beat of a len=7 read, then a clean read
    bus.ic_araddr = $urandom; bus.ic_arlen = 8'd7; bus.ic_arvalid = 1;
    serve_read(2, 0, 0, 0);
    bus.dc_araddr = $urandom; bus.dc_arlen = 8'd1; bus.dc_arvalid = 1;
    serve_read(-1, 0, 0, 0);
    chk("len_err_sticky", len_err, 1);

    // Reset during beat 2 of an icache burst
    bus.ic_araddr = $urandom; bus.ic_arlen = 8'd7; bus.ic_arvalid = 1;
    n = 0;
    while (bus.mem_arvalid !== 1'b1 && n < 50) begin cyc(); n++; end
    chk("rst_test_ar", bus.mem_arvalid, 1);
    bus.mem_arready = 1;
    cyc();
    bus.mem_arready = 0; bus.ic_arvalid = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = $urandom; bus.ic_rready = 1;
    cyc();
    chk("pre_rst_rvalid", bus.ic_rvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rready", bus.mem_rready, 0);
    chk("mid_rst_ic_rvalid", bus.ic_rvalid, 0);
    chk("mid_rst_arvalid", bus.mem_arvalid, 0);
    chk("mid_rst_len_err", len_err, 0);
    $display("[TB] reset pulsed mid-burst");
    clear_inputs();
    cyc(); cyc();
    rst_n = 1;
    pref = GNT_DC;
    err_exp = 0;
    cyc();

    // Pointer back on dcache: contended pair served dcache first
    bus.ic_araddr = $urandom; bus.ic_arlen = 8'd2; bus.ic_arvalid = 1;
    bus.dc_araddr = $urandom; bus.dc_arlen = 8'd2; bus.dc_arvalid = 1;
    serve_read(-1, 0, 0, 0);
    serve_read(-1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
